// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, a constant log2 helper and the exerciser state type.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } exerciser_state_t;

endpackage

// File: rtl/burst_pattern_gen.sv
// Run-wide beat counter producing the counting data pattern (beat k -> k+1).
// Shared by the write driver and the read checker.
module burst_pattern_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data
);

  logic [16:0] run_beat;

  // Run beat counter: restarts at each phase, steps once per data handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_beat <= '0;
    end else if (clear) begin
      run_beat <= '0;
    end else if (advance) begin
      run_beat <= run_beat + 17'd1;
    end
  end

  assign data = DATA_WIDTH'(run_beat) + DATA_WIDTH'(1);

endmodule

// File: rtl/axi4_burst_exerciser.sv
// AXI4 master traffic generator/checker: writes NUM_BURSTS INCR bursts of a
// counting pattern, reads them back and flags any response/data/LAST error.
module axi4_burst_exerciser
  import axi4_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          C_M_AXI_ID_WIDTH           = 1,
  parameter int          C_M_AXI_BURST_LEN          = 16,
  parameter int          C_NUM_BURSTS               = 4,
  parameter int          C_TIMEOUT_CYCLES           = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW          = C_M_AXI_ADDR_WIDTH;
  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8);
  localparam int TO_W        = int'(clog2(C_TIMEOUT_CYCLES)) + 1;

  localparam logic [8:0]      LAST_BEAT  = 9'(C_M_AXI_BURST_LEN - 1);
  localparam logic [8:0]      LAST_BURST = 9'(C_NUM_BURSTS - 1);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(C_TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0]   BASE       = AW'(C_M_TARGET_SLAVE_BASE_ADDR);

  exerciser_state_t state_q, state_d;

  logic                          init_q;
  logic [8:0]                    burst_cnt;
  logic [8:0]                    beat_cnt;
  logic [TO_W-1:0]               to_cnt;
  logic                          error_q;
  logic                          done_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] pat_data;

  logic start, active, timeout, any_hs;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic beat_last, burst_last, r_end, r_bad, phase_change;
  logic unused_ids;

  assign unused_ids = &{1'b0, M_AXI_BID, M_AXI_RID};

  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID  & M_AXI_RREADY;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign active     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign start      = INIT_AXI_TXN & ~init_q & ~active;
  assign beat_last  = (beat_cnt == LAST_BEAT);
  assign burst_last = (burst_cnt == LAST_BURST);
  assign r_end      = beat_last | M_AXI_RLAST;
  assign r_bad      = (M_AXI_RRESP != RESP_OKAY) | (M_AXI_RDATA != pat_data) |
                      (M_AXI_RLAST != beat_last);
  // A handshake landing on the final timeout cycle still counts as progress.
  assign timeout      = active & ~any_hs & (to_cnt == TO_LIMIT);
  assign phase_change = b_hs & burst_last;

  // Address and data channel drive; VALIDs are pure state decodes so they
  // drop the instant the asynchronous reset forces IDLE.
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = BASE + AW'(burst_cnt) * AW'(BURST_BYTES);
  assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWVALID = (state_q == ST_WR_ADDR);
  assign M_AXI_WDATA   = pat_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = beat_last;
  assign M_AXI_WVALID  = (state_q == ST_WR_DATA);
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = M_AXI_AWADDR;
  assign M_AXI_ARLEN   = M_AXI_AWLEN;
  assign M_AXI_ARSIZE  = M_AXI_AWSIZE;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARVALID = (state_q == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_RD_DATA);
  assign TXN_DONE      = done_q;
  assign ERROR         = error_q;

  burst_pattern_gen #(
    .DATA_WIDTH(C_M_AXI_DATA_WIDTH)
  ) u_pattern (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clear   (start | phase_change),
    .advance (w_hs | r_hs),
    .data    (pat_data)
  );

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic; timeout overrides any pending transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_WR_ADDR;
      ST_WR_ADDR: if (aw_hs) state_d = ST_WR_DATA;
      ST_WR_DATA: if (w_hs && beat_last) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = burst_last ? ST_RD_ADDR : ST_WR_ADDR;
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs && r_end) state_d = burst_last ? ST_DONE : ST_RD_ADDR;
      ST_DONE:    if (start) state_d = ST_WR_ADDR;
      default:    state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_DONE;
  end

  // Start-edge detector and completion flag.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      init_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      done_q <= (state_d == ST_DONE);
    end
  end

  // Burst and beat counters; the burst counter rewinds when reads begin.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
    end else if (start) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (w_hs) beat_cnt <= beat_last ? '0 : beat_cnt + 9'd1;
      else if (r_hs) beat_cnt <= r_end ? '0 : beat_cnt + 9'd1;
      if (b_hs) burst_cnt <= burst_last ? '0 : burst_cnt + 9'd1;
      else if (r_hs && r_end) burst_cnt <= burst_cnt + 9'd1;
    end
  end

  // Idle-progress watchdog: restarts on any handshake or state change.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) to_cnt <= '0;
    else if (!active || any_hs || (state_d != state_q)) to_cnt <= '0;
    else to_cnt <= to_cnt + TO_W'(1);
  end

  // Sticky error: cleared only by a new start.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) error_q <= 1'b0;
    else if (start) error_q <= 1'b0;
    else if (timeout || (b_hs && (M_AXI_BRESP != RESP_OKAY)) || (r_hs && r_bad))
      error_q <= 1'b1;
  end

endmodule

// File: tb/tb_axi4_burst_exerciser.sv
// Directed bench: AXI4 slave memory model with optional READY/RVALID stalls,
// fault injection (read corruption, bad BRESP, AWREADY stuck low).
module tb_axi4_burst_exerciser;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int BL = 16;
  localparam int NB = 4;
  localparam int TO = 64;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic aresetn = 1'b1;
  logic init_txn = 1'b0;
  logic txn_done, error;
  logic [IW-1:0] awid;  logic [AW-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst;  logic awlock; logic [3:0] awcache; logic [2:0] awprot; logic [3:0] awqos;
  logic awvalid, awready;
  logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb; logic wlast, wvalid, wready;
  logic [IW-1:0] bid;   logic [1:0] bresp; logic bvalid, bready;
  logic [IW-1:0] arid;  logic [AW-1:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst;  logic arvalid, arready;
  logic [IW-1:0] rid;   logic [DW-1:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;

  axi4_burst_exerciser #(
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(tb_ACLK), .M_AXI_ARESETN(aresetn), .INIT_AXI_TXN(init_txn),
    .TXN_DONE(txn_done), .ERROR(error),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int tests = 0;
  int fails = 0;

  // Slave knobs
  bit stall_en = 0;
  bit corrupt_en = 0;
  bit awr_block = 0;
  int bresp_err_burst = -1;

  // Slave observations
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log[$];
  logic [31:0] ar_log[$];
  logic [31:0] w_log[$];
  int aw_attr_err, ar_attr_err, wlast_err, wstrb_err, stab_err, rd_beats, b_cnt, b_pend;
  int w_beat, r_left, corrupt_state, bad_b_state;
  logic err_at_corrupt, err_after_corrupt, err_at_bad_b, err_after_bad_b;
  logic [31:0] w_addr, r_addr, aw_sv, ar_sv, w_sv;
  logic wl_sv, aw_hold, w_hold, ar_hold;
  bit prev_b_hs, prev_r_hs;

  logic [31:0] exp_addr [NB] = '{32'h4000_0000, 32'h4000_0040, 32'h4000_0080, 32'h4000_00C0};

  // Slave model: updates its outputs at each negedge for the coming posedge
  // and records the handshakes that posedge will complete.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = '0;
    forever begin
      @(negedge tb_ACLK);
      if (aresetn !== 1'b1) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0; prev_b_hs = 0; prev_r_hs = 0;
        r_left = 0; b_pend = 0; w_beat = 0;
      end else begin
        if (corrupt_state == 1) begin err_after_corrupt = error; corrupt_state = 2; end
        if (bad_b_state == 1) begin err_after_bad_b = error; bad_b_state = 2; end
        if (aw_hold && (awvalid !== 1'b1 || awaddr !== aw_sv)) stab_err++;
        if (w_hold && (wvalid !== 1'b1 || wdata !== w_sv || wlast !== wl_sv)) stab_err++;
        if (ar_hold && (arvalid !== 1'b1 || araddr !== ar_sv)) stab_err++;
        if (prev_b_hs) bvalid = 0;
        if (prev_r_hs) rvalid = 0;
        awready = awr_block ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!bvalid && b_pend > 0) begin
          bvalid = 1;
          bresp = (b_cnt == bresp_err_burst) ? 2'b10 : 2'b00;
        end
        if (!rvalid && r_left > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
          rdata = mem.exists(r_addr) ? mem[r_addr] : '0;
          if (corrupt_en && rd_beats == 36) rdata = '0;
          rlast = (r_left == 1);
          rresp = 2'b00;
          rvalid = 1;
        end
        prev_b_hs = bvalid && bready;
        prev_r_hs = rvalid && rready;
        if (awvalid && awready) begin
          aw_log.push_back(awaddr);
          if (awlen !== 8'd15 || awsize !== 3'd2 || awburst !== 2'b01 || awid !== '0 ||
              awlock !== 1'b0 || awcache !== 4'b0011 || awprot !== 3'd0 || awqos !== 4'd0)
            aw_attr_err++;
          w_addr = awaddr;
          w_beat = 0;
        end
        if (wvalid && wready) begin
          mem[w_addr] = wdata;
          w_log.push_back(wdata);
          w_addr += 4;
          if (wlast !== (w_beat == BL - 1)) wlast_err++;
          if (wstrb !== 4'hF) wstrb_err++;
          if (wlast) begin b_pend++; w_beat = 0; end
          else w_beat++;
        end
        if (prev_b_hs) begin
          if (b_cnt == bresp_err_burst) begin err_at_bad_b = error; bad_b_state = 1; end
          b_cnt++;
          b_pend--;
        end
        if (arvalid && arready) begin
          ar_log.push_back(araddr);
          if (arlen !== 8'd15 || arsize !== 3'd2 || arburst !== 2'b01 || arid !== '0)
            ar_attr_err++;
          r_addr = araddr;
          r_left = int'(arlen) + 1;
        end
        if (prev_r_hs) begin
          if (corrupt_en && corrupt_state == 0 && rd_beats == 36) begin
            err_at_corrupt = error;
            corrupt_state = 1;
          end
          rd_beats++;
          r_addr += 4;
          r_left--;
        end
        aw_hold = awvalid && !awready; aw_sv = awaddr;
        w_hold  = wvalid && !wready;   w_sv = wdata; wl_sv = wlast;
        ar_hold = arvalid && !arready; ar_sv = araddr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic clear_model();
    aw_log.delete(); ar_log.delete(); w_log.delete();
    aw_attr_err = 0; ar_attr_err = 0; wlast_err = 0; wstrb_err = 0; stab_err = 0;
    rd_beats = 0; b_cnt = 0; corrupt_state = 0; bad_b_state = 0;
    err_at_corrupt = 1'bx; err_after_corrupt = 1'bx; err_at_bad_b = 1'bx; err_after_bad_b = 1'bx;
  endtask

  task automatic do_run(input int budget, output bit finished);
    @(negedge tb_ACLK);
    init_txn = 1;
    finished = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge tb_ACLK);
      if (txn_done === 1'b1) begin finished = 1; break; end
    end
    init_txn = 0;
    @(negedge tb_ACLK);
  endtask

  task automatic test_reset();
    aresetn = 1; #1 aresetn = 0;
    repeat (2) @(negedge tb_ACLK);
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid got %b want 0", awvalid); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid got %b want 0", wvalid); end
    tests++; if (bready !== 1'b0) begin fails++; $display("FAIL reset_bready got %b want 0", bready); end
    tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
    tests++; if (rready !== 1'b0) begin fails++; $display("FAIL reset_rready got %b want 0", rready); end
    tests++; if (txn_done !== 1'b0) begin fails++; $display("FAIL reset_txn_done got %b want 0", txn_done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    aresetn = 1;
    @(negedge tb_ACLK);
  endtask

  task automatic test_basic(input string tag);
    bit fin;
    int n;
    clear_model();
    do_run(5000, fin);
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL %s_done_wait got timeout want TXN_DONE", tag); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL %s_error got %b want 0", tag, error); end
    tests++; if (aw_log.size() != NB) begin fails++; $display("FAIL %s_aw_count got %0d want %0d", tag, aw_log.size(), NB); end
    tests++; if (ar_log.size() != NB) begin fails++; $display("FAIL %s_ar_count got %0d want %0d", tag, ar_log.size(), NB); end
    n = (aw_log.size() < NB) ? aw_log.size() : NB;
    for (int b = 0; b < n; b++) begin
      tests++; if (aw_log[b] !== exp_addr[b]) begin fails++; $display("FAIL %s_awaddr[%0d] got %h want %h", tag, b, aw_log[b], exp_addr[b]); end
    end
    n = (ar_log.size() < NB) ? ar_log.size() : NB;
    for (int b = 0; b < n; b++) begin
      tests++; if (ar_log[b] !== exp_addr[b]) begin fails++; $display("FAIL %s_araddr[%0d] got %h want %h", tag, b, ar_log[b], exp_addr[b]); end
    end
    tests++; if (w_log.size() != NB * BL) begin fails++; $display("FAIL %s_w_count got %0d want %0d", tag, w_log.size(), NB * BL); end
    n = (w_log.size() < NB * BL) ? w_log.size() : NB * BL;
    for (int k = 0; k < n; k++) begin
      tests++; if (w_log[k] !== 32'(k + 1)) begin fails++; $display("FAIL %s_wdata[%0d] got %h want %h", tag, k, w_log[k], 32'(k + 1)); end
    end
    tests++; if (rd_beats != NB * BL) begin fails++; $display("FAIL %s_r_beats got %0d want %0d", tag, rd_beats, NB * BL); end
    tests++; if (aw_attr_err + ar_attr_err != 0) begin fails++; $display("FAIL %s_ax_attr got %0d bad want 0", tag, aw_attr_err + ar_attr_err); end
    tests++; if (wlast_err + wstrb_err != 0) begin fails++; $display("FAIL %s_wlast_wstrb got %0d bad want 0", tag, wlast_err + wstrb_err); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL %s_valid_stable got %0d changes want 0", tag, stab_err); end
  endtask

  task automatic test_stalls();
    stall_en = 1;
    test_basic("stall");
    stall_en = 0;
  endtask

  task automatic test_corrupt();
    bit fin;
    clear_model();
    corrupt_en = 1;
    do_run(5000, fin);
    corrupt_en = 0;
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL corrupt_done_wait got timeout want TXN_DONE"); end
    tests++; if (err_at_corrupt !== 1'b0) begin fails++; $display("FAIL corrupt_err_before got %b want 0", err_at_corrupt); end
    tests++; if (err_after_corrupt !== 1'b1) begin fails++; $display("FAIL corrupt_err_after got %b want 1", err_after_corrupt); end
    tests++; if (rd_beats != NB * BL) begin fails++; $display("FAIL corrupt_r_beats got %0d want %0d", rd_beats, NB * BL); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL corrupt_error_final got %b want 1", error); end
  endtask

  task automatic test_bresp();
    bit fin;
    clear_model();
    bresp_err_burst = 2;
    do_run(5000, fin);
    bresp_err_burst = -1;
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL bresp_done_wait got timeout want TXN_DONE"); end
    tests++; if (err_at_bad_b !== 1'b0) begin fails++; $display("FAIL bresp_err_before got %b want 0", err_at_bad_b); end
    tests++; if (err_after_bad_b !== 1'b1) begin fails++; $display("FAIL bresp_err_after got %b want 1", err_after_bad_b); end
    tests++; if (ar_log.size() != NB) begin fails++; $display("FAIL bresp_ar_count got %0d want %0d", ar_log.size(), NB); end
    tests++; if (rd_beats != NB * BL) begin fails++; $display("FAIL bresp_r_beats got %0d want %0d", rd_beats, NB * BL); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL bresp_error_final got %b want 1", error); end
  endtask

  task automatic test_timeout();
    int n;
    clear_model();
    awr_block = 1;
    @(negedge tb_ACLK);
    init_txn = 1;
    for (int i = 0; i < 10 && awvalid !== 1'b1; i++) @(negedge tb_ACLK);
    tests++; if (awvalid !== 1'b1) begin fails++; $display("FAIL timeout_awvalid_rise got %b want 1", awvalid); end
    n = 0;
    while (awvalid === 1'b1 && n < 200) begin
      n++;
      @(negedge tb_ACLK);
    end
    tests++; if (n != TO) begin fails++; $display("FAIL timeout_cycles got %0d want %0d", n, TO); end
    tests++; if (txn_done !== 1'b1) begin fails++; $display("FAIL timeout_txn_done got %b want 1", txn_done); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_error got %b want 1", error); end
    tests++; if (ar_log.size() != 0 || aw_log.size() != 0) begin fails++; $display("FAIL timeout_no_hs got %0d want 0", ar_log.size() + aw_log.size()); end
    init_txn = 0;
    awr_block = 0;
    @(negedge tb_ACLK);
  endtask

  task automatic test_reset_mid();
    clear_model();
    @(negedge tb_ACLK);
    init_txn = 1;
    for (int i = 0; i < 200 && w_log.size() < 5; i++) @(negedge tb_ACLK);
    tests++; if (wvalid !== 1'b1) begin fails++; $display("FAIL midrst_in_wr_data got wvalid=%b want 1", wvalid); end
    #1 aresetn = 0;
    init_txn = 0;
    #1;
    tests++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      fails++; $display("FAIL midrst_valids got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    tests++; if ({txn_done, error} !== 2'b0) begin fails++; $display("FAIL midrst_done_err got %b want 00", {txn_done, error}); end
    repeat (2) @(negedge tb_ACLK);
    aresetn = 1;
    @(negedge tb_ACLK);
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL midrst_idle_after got awvalid=%b want 0", awvalid); end
    test_basic("rerun");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic("basic");
    test_stalls();
    test_corrupt();
    test_bresp();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
